// File: rtl/event_onehot_arbiter.sv
// Edge-detecting event arbiter: latches rising edges of ev into a sticky pending register and
// presents one granted event at a time as one-hot plus code. Define ARB_ROUND_ROBIN_EN for round-robin.
module event_onehot_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ev,
   input  logic       out_ready,
   input  logic       ovf_clr,
   output logic       out_valid,
   output logic [7:0] out_onehot,
   output logic [2:0] out_code,
   output logic [7:0] pending,
   output logic       ovf
);

   typedef enum logic {StIdle, StPresent} state_e;

   state_e     state_q, state_d;
   logic [7:0] ev_q;
   logic [7:0] pending_q, pending_d;
   logic [7:0] rise, clr;
   logic [7:0] onehot_q, onehot_d;
   logic [2:0] code_q, code_d;
   logic       valid_q, valid_d;
   logic       ovf_q, ovf_d;
   logic       handshake;
   logic       sel_found;
   logic [2:0] sel_code;

   assign rise      = ev & ~ev_q;
   assign handshake = valid_q & out_ready;
   assign clr       = handshake ? onehot_q : 8'h00;

   // A rise on the bit being retired re-arms it (set wins) and is not counted as lost.
   assign pending_d = (pending_q & ~clr) | rise;
   assign ovf_d     = (|(rise & pending_q & ~clr)) | (ovf_q & ~ovf_clr);

`ifdef ARB_ROUND_ROBIN_EN
   logic [2:0] last_grant_q;
   logic [2:0] idx;

   always_comb begin
      sel_found = 1'b0;
      sel_code  = 3'd0;
      idx       = 3'd0;
      for (int i = 1; i <= 8; i++) begin
         idx = last_grant_q + 3'(i);
         if (!sel_found && pending_q[idx]) begin
            sel_found = 1'b1;
            sel_code  = idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 3'd7;
      end else if (handshake) begin
         last_grant_q <= code_q;
      end
   end
`else
   // Ascending scan so the highest set index is the one left selected.
   always_comb begin
      sel_found = 1'b0;
      sel_code  = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (pending_q[i]) begin
            sel_found = 1'b1;
            sel_code  = 3'(i);
         end
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      onehot_d = onehot_q;
      code_d   = code_q;
      unique case (state_q)
         StIdle: begin
            if (sel_found) begin
               valid_d  = 1'b1;
               onehot_d = 8'd1 << sel_code;
               code_d   = sel_code;
               state_d  = StPresent;
            end
         end
         StPresent: begin
            if (out_ready) begin
               valid_d  = 1'b0;
               onehot_d = 8'h00;
               code_d   = 3'd0;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         ev_q      <= 8'h00;
         pending_q <= 8'h00;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
         onehot_q  <= 8'h00;
         code_q    <= 3'd0;
      end else begin
         state_q   <= state_d;
         ev_q      <= ev;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
         valid_q   <= valid_d;
         onehot_q  <= onehot_d;
         code_q    <= code_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_onehot = onehot_q;
   assign out_code   = code_q;
   assign pending    = pending_q;
   assign ovf        = ovf_q;

endmodule
